// File: rtl/b10_pkg.sv
// Shared types and constants for the b10 voting controller and its remote peer.
package b10_pkg;

    localparam int VOTE_W = 4;

    localparam logic [VOTE_W-1:0] VOTE_ACCEPT = 4'h6;
    localparam logic [VOTE_W-1:0] VOTE_ZERO   = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK_WAIT,
        REP_WAIT,
        REP_DRIVE,
        REP_CLOSE,
        HALT
    } peer_state_t;

endpackage

// File: rtl/b10_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module b10_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/b10_vote_peer.sv
// Remote handshake partner for b10: requests a vote, accepts it or answers with a
// corrected vote, and raises a sticky error after too many consecutive rejections.
module b10_vote_peer
    import b10_pkg::*;
#(
    parameter logic [VOTE_W-1:0] ACCEPT_VOTE = VOTE_ACCEPT,
    parameter logic [VOTE_W-1:0] REPLY_VOTE  = VOTE_ACCEPT,
    parameter int                CNT_W       = 8,
    parameter int                MAX_RETRY   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              cts,
    input  logic              ctr,
    input  logic [VOTE_W-1:0] v_out,
    output logic              rtr,
    output logic              rts,
    output logic [VOTE_W-1:0] v_in,
    output logic [VOTE_W-1:0] last_vote,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  reject_cnt,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    peer_state_t       state, state_nxt;
    logic [3:0]        retry_cnt, retry_nxt;
    logic              rtr_nxt, rts_nxt, err_nxt;
    logic [VOTE_W-1:0] v_in_nxt, last_vote_nxt;
    logic              acc_inc, rej_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (enable) state_nxt = REQ;
            REQ:       if (cts)    state_nxt = (v_out == ACCEPT_VOTE) ? ACK_WAIT : REP_WAIT;
            ACK_WAIT:  if (!cts)   state_nxt = IDLE;
            REP_WAIT:  if (ctr)    state_nxt = REP_DRIVE;
            REP_DRIVE: if (!ctr)   state_nxt = REP_CLOSE;
            REP_CLOSE: if (!cts)   state_nxt = (retry_cnt == RETRY_LIMIT) ? HALT : IDLE;
            HALT:      if (!enable) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rtr_nxt       = rtr;
        rts_nxt       = rts;
        v_in_nxt      = v_in;
        last_vote_nxt = last_vote;
        err_nxt       = err;
        retry_nxt     = retry_cnt;
        acc_inc       = 1'b0;
        rej_inc       = 1'b0;
        case (state)
            IDLE: if (enable) rtr_nxt = 1'b1;
            REQ: begin
                if (cts) begin
                    last_vote_nxt = v_out;
                    if (v_out == ACCEPT_VOTE) begin
                        rtr_nxt   = 1'b0;
                        acc_inc   = 1'b1;
                        retry_nxt = 4'd0;
                    end else begin
                        rej_inc   = 1'b1;
                        retry_nxt = (retry_cnt >= RETRY_LIMIT) ? RETRY_LIMIT : retry_cnt + 4'd1;
                    end
                end
            end
            REP_WAIT: begin
                if (ctr) begin
                    v_in_nxt = REPLY_VOTE;
                    rts_nxt  = 1'b1;
                end
            end
            REP_DRIVE: begin
                if (!ctr) begin
                    rts_nxt  = 1'b0;
                    rtr_nxt  = 1'b0;
                    v_in_nxt = VOTE_ZERO;
                end
            end
            REP_CLOSE: if (!cts && (retry_cnt == RETRY_LIMIT)) err_nxt = 1'b1;
            ACK_WAIT, HALT: ;
            default: begin
                rtr_nxt  = 1'b0;
                rts_nxt  = 1'b0;
                v_in_nxt = VOTE_ZERO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rtr       <= 1'b0;
            rts       <= 1'b0;
            v_in      <= VOTE_ZERO;
            last_vote <= VOTE_ZERO;
            err       <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            rtr       <= rtr_nxt;
            rts       <= rts_nxt;
            v_in      <= v_in_nxt;
            last_vote <= last_vote_nxt;
            err       <= err_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    assign busy = (state != IDLE);

    b10_sat_counter #(.W(CNT_W)) u_accept_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (acc_inc),
        .count (accept_cnt)
    );

    b10_sat_counter #(.W(CNT_W)) u_reject_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (rej_inc),
        .count (reject_cnt)
    );

endmodule

// File: tb/tb_b10_vote_peer.sv
// Directed bench for b10_vote_peer: a per-cycle vector table plus multi-round sequences.
module tb_b10_vote_peer;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable, cts, ctr;
    logic [3:0] v_out;

    logic       rtr, rts, busy, err;
    logic [3:0] v_in, last_vote;
    logic [7:0] accept_cnt, reject_cnt;

    logic       rtr2, rts2, busy2, err2;
    logic [3:0] v_in2, last_vote2;
    logic [1:0] accept_cnt2, reject_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    b10_vote_peer dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cts        (cts),
        .ctr        (ctr),
        .v_out      (v_out),
        .rtr        (rtr),
        .rts        (rts),
        .v_in       (v_in),
        .last_vote  (last_vote),
        .accept_cnt (accept_cnt),
        .reject_cnt (reject_cnt),
        .busy       (busy),
        .err        (err)
    );

    b10_vote_peer #(.CNT_W(2)) dut_narrow (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cts        (cts),
        .ctr        (ctr),
        .v_out      (v_out),
        .rtr        (rtr2),
        .rts        (rts2),
        .v_in       (v_in2),
        .last_vote  (last_vote2),
        .accept_cnt (accept_cnt2),
        .reject_cnt (reject_cnt2),
        .busy       (busy2),
        .err        (err2)
    );

    typedef struct packed {
        logic       en;
        logic       cts;
        logic       ctr;
        logic [3:0] vo;
        logic       rtr;
        logic       rts;
        logic [3:0] vi;
        logic [3:0] lv;
        logic       busy;
        logic       err;
        logic [7:0] acc;
        logic [7:0] rej;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {4'h0, rtr, rts, v_in, last_vote, busy, err, accept_cnt, reject_cnt};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0; cts = 1'b0; ctr = 1'b0; v_out = 4'h0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One full round as b10 would drive it; enable is dropped once the round has started.
    task automatic run_round(input logic [3:0] vote);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        cts = 1'b1; v_out = vote;
        tick();
        if (vote == 4'h6) begin
            cts = 1'b0;
            tick();
        end else begin
            check("rep_wait_rts_low", {31'd0, rts}, 32'd0);
            ctr = 1'b1;
            tick();
            check("rep_drive", {27'd0, rts, v_in}, {27'd0, 1'b1, 4'h6});
            ctr = 1'b0;
            tick();
            check("rep_close", {26'd0, rts, rtr, v_in}, 32'd0);
            cts = 1'b0;
            tick();
        end
    endtask

    initial begin
        //         en    cts   ctr   vo      rtr   rts   vi    lv    busy  err   acc    rej
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 8'd0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 4'h0, 4'h6, 1'b1, 1'b0, 8'd1, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 4'h0, 4'h6, 1'b1, 1'b0, 8'd1, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h6, 1'b0, 1'b0, 8'd1, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h6, 1'b0, 1'b0, 8'd1, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h6, 1'b1, 1'b0, 8'd1, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 8'd1, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 8'd1, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h6, 4'h3, 1'b1, 1'b0, 8'd1, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 4'h6, 4'h3, 1'b1, 1'b0, 8'd1, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 8'd1, 8'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 8'd1, 8'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 8'd1, 8'd1};

        reset = 1'b0;
        enable = 1'b0; cts = 1'b0; ctr = 1'b0; v_out = 4'h0;
        #3;
        check("reset_state", outs(), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            enable = vecs[i].en;
            cts    = vecs[i].cts;
            ctr    = vecs[i].ctr;
            v_out  = vecs[i].vo;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {4'h0, vecs[i].rtr, vecs[i].rts, vecs[i].vi, vecs[i].lv,
                   vecs[i].busy, vecs[i].err, vecs[i].acc, vecs[i].rej});
        end

        // Reject, accept (clears retries), then three rejects reach the limit.
        do_reset();
        run_round(4'h9);
        check("err_after_first_reject", {31'd0, err}, 32'd0);
        run_round(4'h6);
        run_round(4'h9);
        run_round(4'h9);
        check("err_after_two_rejects", {30'd0, err, busy}, 32'd0);
        run_round(4'h9);
        check("halt_entry", {29'd0, err, busy, rtr}, {29'd0, 3'b110});
        check("counts_after_halt", {16'd0, accept_cnt, reject_cnt}, {16'd0, 8'd1, 8'd4});
        tick();
        check("halt_exit", {30'd0, busy, err}, {30'd0, 2'b01});

        // Asynchronous reset while the reply is being driven.
        enable = 1'b1;
        tick();
        enable = 1'b0; cts = 1'b1; v_out = 4'h3;
        tick();
        ctr = 1'b1;
        tick();
        check("pre_reset_drive", {31'd0, rts}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {22'd0, rtr, rts, v_in, busy, err, accept_cnt[1:0], 1'b0}, 32'd0);
        check("async_reset_cnt", {16'd0, accept_cnt, reject_cnt}, 32'd0);
        cts = 1'b0; ctr = 1'b0; v_out = 4'h0;
        #2;
        reset = 1'b1;
        tick();
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        // Narrow counters saturate at all-ones.
        for (int r = 0; r < 5; r++) run_round(4'h6);
        check("wide_accept_5", {24'd0, accept_cnt}, 32'd5);
        check("narrow_accept_sat", {28'd0, accept_cnt2, reject_cnt2}, {28'd0, 2'b11, 2'b00});
        check("idle_after_rounds", {30'd0, busy, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
